rv_inst_aligner: RTL and testbench
==================================

# rv_inst_aligner

Parametrised instruction fetch aligner for the RV32IC front end. It accepts fixed-width fetch words, buffers them as a halfword stream, and emits one aligned instruction per handshake. Each instruction is either a 16-bit compressed instruction or a 32-bit instruction, and may straddle fetch-word boundaries. Each output carries its size and PC. It sits between the fetch unit and the instruction field parser; the parser consumes `out_instr` directly.

## Interface
- `FETCH_W`, 32: fetch word width in bits; legal values 16, 32, 64.
- `DEPTH_HW`, 8: halfword buffer depth; power of 2, at least 2*FETCH_W/16.
- `RESET_PC`, 32'h8000_0000: PC of the first instruction after reset.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all buffered halfwords and redirect to `flush_pc`.
- `flush_pc`  in  32  new PC; bit 0 must be 0.
- `fetch_valid`  in  1  fetch word present.
- `fetch_ready`  out  1  aligner accepts a fetch word this cycle.
- `fetch_data`  in  FETCH_W  fetch word; halfword 0 is at bits [15:0] and is the lowest address.
- `out_valid`  out  1  aligned instruction available.
- `out_ready`  in  1  consumer takes the instruction.
- `out_instr`  out  32  instruction; a compressed instruction is zero-extended in [31:16].
- `out_is_c`  out  1  1 = 16-bit compressed, 0 = 32-bit.
- `out_pc`  out  32  byte address of `out_instr`.

## Operation
- **State**
  - Circular halfword buffer of `DEPTH_HW` entries with read pointer, write pointer and count (width log2(DEPTH_HW)+1).
  - PC register.
  - Drop counter, width log2(FETCH_W/16), or 1 bit when FETCH_W=16.
- **Push** (`fetch_valid & fetch_ready`): append halfwords 0..FETCH_W/16-1 in order, skipping the first `drop` halfwords; then clear `drop`.
- **Size detection** on the head halfword h0:
  - h0[1:0]==2'b11 means 32-bit; it needs count >= 2, and `out_instr` = {h1, h0}.
  - Otherwise the instruction is compressed; it needs count >= 1, and `out_instr` = {16'h0, h0}.
- **Output**
  - `out_valid` is 1 when the required halfwords are present.
  - `out_is_c` = ~(h0[1:0]==2'b11).
  - `out_pc` = PC register.
  - All output signals are combinational from registered state only; there is no path from `out_ready` to `fetch_ready`.
- **Pop** (`out_valid & out_ready`):
  - Remove 1 or 2 halfwords.
  - PC += 2 or 4, modulo 2^32 (0xFFFF_FFFE + 2 = 0x0000_0000).
- **Space rule:** `fetch_ready` = `rst_n` & ~`flush` & (count <= DEPTH_HW - FETCH_W/16). The pop in the same cycle is not credited.
- **Simultaneous push and pop:** both take effect; count += pushed - popped.
- **Flush**, highest priority:
  - count and pointers go to 0.
  - PC = `flush_pc`.
  - `drop` = `flush_pc`[log2(FETCH_W/8)-1:1], or 0 when FETCH_W=16.
  - Any push or pop in the flush cycle is ignored; `out_valid` = 0 in the flush cycle.
  - The first fetch word accepted after a flush is the aligned word containing `flush_pc`.
- **Reset** (`rst_n`=0 at an edge): count = 0, pointers = 0, PC = `RESET_PC`, `drop` = RESET_PC drop bits.
  - Reset mid-operation discards everything, including a half-received 32-bit instruction.
- **Content is not validated:** halfword 0x0000 is emitted as a compressed instruction; the parser flags it.

## Timing
- Reset values:
  - `out_valid` = 0, `out_instr` = 0, `out_is_c` = 1, `out_pc` = RESET_PC.
  - `fetch_ready` = 0 while `rst_n` = 0, and 1 in the first cycle after release.
- Latency: a fetch word accepted at edge N is visible on the outputs after edge N, i.e. in cycle N+1.
- Throughput: one instruction per cycle while the buffer holds enough halfwords.
- A 32-bit instruction split across two fetch words becomes valid in the cycle after the second word is accepted.
- Full: with the default parameters, a word is accepted only when count <= 6. At count 7 or 8, `fetch_ready` = 0 until pops reduce count.
- Empty, or a lone upper-half-of-32-bit head: `out_valid` = 0 and the outputs hold the head contents; consumers ignore them.
- Handshake rules:
  - `out_instr`, `out_is_c` and `out_pc` are stable while `out_valid` = 1 and `out_ready` = 0, unless `flush` or reset occurs.
  - `fetch_ready` does not depend on `fetch_valid`.

## Test plan
Unless noted, FETCH_W=32, DEPTH_HW=8, RESET_PC=0x8000_0000.

1. Release reset, push 0x00A0_0093 -> next cycle `out_valid`=1, `out_instr`=0x00A0_0093, `out_is_c`=0, `out_pc`=0x8000_0000; after the pop, `out_valid`=0.
2. Push 0x0001_4505 with `out_ready`=1 -> instruction 0x0000_4505 at 0x8000_0000, then 0x0000_0001 at 0x8000_0002, both with `out_is_c`=1.
3. Push 0x0093_4501 then 0x4501_00A0 -> 0x4501 (C) at 0x8000_0000; `out_valid`=0 until the second word is accepted; then 0x00A0_0093 (32-bit) at 0x8000_0002, then 0x4501 (C) at 0x8000_0006.
4. Hold `out_ready`=0 and push four words -> `fetch_ready` drops after the 4th (count 8). Release `out_ready`: all 8 halfwords are emitted in order with no loss or duplication, and `fetch_ready` returns when count <= 6.
5. With 3 halfwords buffered, pulse `flush` with `flush_pc`=0x8000_1002, then push 0x0001_4505 -> `out_valid`=0 in the flush cycle; the only output is 0x0000_0001 at 0x8000_1002 and nothing stale appears.
6. Flush to 0xFFFF_FFFC and push 0x0001_4505 -> C instructions at 0xFFFF_FFFC and 0xFFFF_FFFE, with the PC register wrapping to 0x0000_0000. Then assert reset while a half 32-bit instruction is buffered -> outputs return to reset values, `out_pc`=0x8000_0000.

Source files
------------

// File: rtl/rv_inst_aligner.sv
// rv_inst_aligner: buffers fetch words as halfwords and emits aligned RV32IC instructions with size and PC.
module rv_inst_aligner #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [31:0]        flush_pc,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_is_c,
  output logic [31:0]        out_pc
);
  localparam int NHW = FETCH_W / 16;
  localparam int AW  = $clog2(DEPTH_HW);
  localparam int CW  = AW + 1;
  localparam int DW  = (NHW > 1) ? $clog2(NHW) : 1;

  logic [15:0]   mem [DEPTH_HW];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt, push_n, pop_n;
  logic [31:0]   pc;
  logic [DW-1:0] drop;
  logic [15:0]   h0, h1;
  logic          is32, push, pop;

  // Halfwords of the first fetch word that precede the target PC are skipped.
  function automatic logic [DW-1:0] drop_of(input logic [31:0] p);
    return (NHW > 1) ? p[DW:1] : '0;
  endfunction

  always_comb begin
    h0          = mem[rd];
    h1          = mem[rd + AW'(1)];
    is32        = h0[1:0] == 2'b11;
    out_instr   = is32 ? {h1, h0} : {16'h0, h0};
    out_is_c    = ~is32;
    out_pc      = pc;
    out_valid   = rst_n & ~flush & (cnt >= (is32 ? CW'(2) : CW'(1)));
    fetch_ready = rst_n & ~flush & (cnt <= CW'(DEPTH_HW - NHW));
    push        = fetch_valid & fetch_ready;
    pop         = out_valid & out_ready;
    push_n      = push ? CW'(NHW) - CW'(drop) : '0;
    pop_n       = pop ? (is32 ? CW'(2) : CW'(1)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_HW; i++) mem[i] <= '0;
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      pc   <= RESET_PC;
      drop <= drop_of(RESET_PC);
    end else if (flush) begin
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      pc   <= flush_pc;
      drop <= drop_of(flush_pc);
    end else begin
      if (push) begin
        for (int i = 0; i < NHW; i++)
          if (i >= int'(drop)) mem[wr + AW'(i - int'(drop))] <= fetch_data[16*i +: 16];
        wr   <= wr + push_n[AW-1:0];
        drop <= '0;
      end
      if (pop) begin
        rd <= rd + pop_n[AW-1:0];
        pc <= pc + (is32 ? 32'd4 : 32'd2);
      end
      cnt <= cnt + push_n - pop_n;
    end
  end
endmodule

// File: tb/tb_rv_inst_aligner.sv
// tb_rv_inst_aligner: random and directed stimulus scored against a halfword-stream decode model.
module tb_rv_inst_aligner;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 0, rst_n = 0, flush = 0, fetch_valid = 0, out_ready = 0;
  logic [31:0] flush_pc = 0, fetch_data = 0;
  logic        fetch_ready, out_valid, out_is_c;
  logic [31:0] out_instr, out_pc;

  always #5 clk = ~clk;

  rv_inst_aligner #(.FETCH_W(32), .DEPTH_HW(8), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_is_c(out_is_c), .out_pc(out_pc)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        is_c;
    logic [31:0] pc;
  } exp_t;

  logic [15:0] hq[$];
  exp_t        eq[$];
  logic [31:0] spc = RPC;
  logic        mdrop = 1'b0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int mcount();
    int n = hq.size();
    foreach (eq[i]) n += eq[i].is_c ? 1 : 2;
    return n;
  endfunction

  // Turn buffered halfwords into complete instructions in program order.
  function automatic void extract();
    while (hq.size() > 0) begin
      if (hq[0][1:0] == 2'b11) begin
        if (hq.size() < 2) break;
        eq.push_back(exp_t'{instr: {hq[1], hq[0]}, is_c: 1'b0, pc: spc});
        spc += 4;
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else begin
        eq.push_back(exp_t'{instr: {16'h0, hq[0]}, is_c: 1'b1, pc: spc});
        spc += 2;
        void'(hq.pop_front());
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("fetch_ready_in_reset", {31'b0, fetch_ready}, 32'd0);
      hq.delete();
      eq.delete();
      spc = RPC;
      mdrop = RPC[1];
    end else begin
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, (!flush && mcount() <= 6)});
      chk("out_valid", {31'b0, out_valid}, {31'b0, (!flush && eq.size() > 0)});
      if (out_valid && eq.size() > 0) begin
        chk("out_instr", out_instr, eq[0].instr);
        chk("out_is_c", {31'b0, out_is_c}, {31'b0, eq[0].is_c});
        chk("out_pc", out_pc, eq[0].pc);
      end
      if (flush) begin
        hq.delete();
        eq.delete();
        spc = flush_pc;
        mdrop = flush_pc[1];
      end else begin
        if (out_valid && out_ready && eq.size() > 0) void'(eq.pop_front());
        if (fetch_valid && fetch_ready) begin
          for (int i = 0; i < 2; i++)
            if (!(i == 0 && mdrop)) hq.push_back(fetch_data[16*i +: 16]);
          mdrop = 1'b0;
        end
        extract();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_word(input logic [31:0] w);
    logic acc = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = w;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = fetch_ready;
      step();
    end
    chk("push_accept", {31'b0, acc}, 32'd1);
    fetch_valid = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_is_c", {31'b0, out_is_c}, 32'd1);
    chk("rst_out_pc", out_pc, RPC);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(2);
    chk_reset();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, fetch_ready}, 32'd1);
    chk_reset();
    out_ready = 1'b1;
    push_word(32'h00A0_0093);
    idle(3);
    push_word(32'h0001_4505);
    idle(3);
    push_word(32'h0093_4501);
    idle(2);
    push_word(32'h4501_00A0);
    idle(4);
    out_ready = 1'b0;
    push_word(32'h00A0_0093);
    push_word(32'h0001_4505);
    push_word(32'h4501_0093);
    push_word(32'h4505_00A0);
    idle(2);
    out_ready = 1'b1;
    idle(10);
    out_ready = 1'b0;
    push_word(32'h4505_4505);
    push_word(32'h4505_4505);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h8000_1002;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    push_word(32'h0001_4505);
    idle(4);
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    push_word(32'h0001_4505);
    idle(3);
    push_word(32'h0093_4505);
    idle(3);
    rst_n = 1'b0;
    step();
    chk_reset();
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 3000; c++) begin
      fetch_valid = $urandom_range(0, 9) < 7;
      fetch_data  = $urandom;
      out_ready   = $urandom_range(0, 9) < 7;
      flush       = $urandom_range(0, 49) == 0;
      flush_pc    = $urandom & 32'hFFFF_FFFE;
      rst_n       = $urandom_range(0, 199) != 0;
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    fetch_valid = 1'b0;
    out_ready = 1'b1;
    idle(20);
    chk("drained", eq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
